keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/kp_timer.sv | 34 +++
 rtl/keypad_scan.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_pkg : shared types and constants for the 4x4 keypad scanner       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package keypad_pkg;

    localparam int unsigned c_NUM_LINES = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Lowest set column wins when several columns are active together.
    function automatic logic [1:0] lowest_col(input logic [c_NUM_LINES-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = c_NUM_LINES - 1; i >= 0; i--) begin
            if (cols[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kp_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kp_timer : saturating up-counter, counts 0..COUNT-1 and flags terminal   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module kp_timer #(
    parameter int COUNT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam int c_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [c_W-1:0] c_TERM = c_W'(COUNT - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_TERM)) begin
            r_count <= r_count + c_W'(1);
        end
    end

    assign o_done = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scan : 4x4 matrix keypad row scanner with press/release debounce  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int ROW_DWELL       = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [c_NUM_LINES-1:0] colIn,
    output logic [c_NUM_LINES-1:0] rowOut,
    output key_code_t              keyCode,
    output logic                   keyValid,
    output logic                   keyHeld
);

    kp_state_t              r_state;
    kp_state_t              w_state_nxt;
    logic [c_NUM_LINES-1:0] r_row_out;
    logic [1:0]             r_row_idx;
    logic [1:0]             r_col_idx;
    key_code_t              r_key_code;
    logic                   r_key_valid;
    logic                   r_key_held;

    logic       w_dwell_done, w_dwell_clr, w_dwell_en;
    logic       w_stable_done, w_stable_clr, w_stable_en;
    logic       w_col_any, w_match;
    logic [1:0] w_col_low;
    logic       w_rotate, w_latch, w_accept, w_release;

    assign w_col_any = |colIn;
    assign w_col_low = lowest_col(colIn);
    assign w_match   = w_col_any && (w_col_low == r_col_idx);
    assign w_dwell_en = (r_state == SCAN);

    kp_timer #(.COUNT(ROW_DWELL)) u_dwell (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_dwell_clr),
        .i_enable (w_dwell_en),
        .o_done   (w_dwell_done)
    );

    kp_timer #(.COUNT(DEBOUNCE_CYCLES)) u_stable (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_stable_clr),
        .i_enable (w_stable_en),
        .o_done   (w_stable_done)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= SCAN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rotate     = 1'b0;
        w_latch      = 1'b0;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        w_dwell_clr  = 1'b1;
        w_stable_clr = 1'b0;
        w_stable_en  = 1'b0;
        case (r_state)
            SCAN: begin
                // Columns are only trusted at the end of the dwell window.
                w_dwell_clr  = w_dwell_done;
                w_stable_clr = 1'b1;
                if (w_dwell_done) begin
                    if (w_col_any) begin
                        w_latch     = 1'b1;
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        w_rotate = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (w_match) begin
                    if (w_stable_done) begin
                        w_accept    = 1'b1;
                        w_state_nxt = PRESSED;
                    end else begin
                        w_stable_en = 1'b1;
                    end
                end else begin
                    w_rotate    = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            PRESSED: begin
                w_stable_clr = 1'b1;
                if (!w_col_any) w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!w_col_any) begin
                    if (w_stable_done) begin
                        w_release   = 1'b1;
                        w_rotate    = 1'b1;
                        w_state_nxt = SCAN;
                    end else begin
                        w_stable_en = 1'b1;
                    end
                end else begin
                    w_state_nxt = PRESSED;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_row_out   <= 4'b0001;
            r_row_idx   <= 2'd0;
            r_col_idx   <= 2'd0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            if (w_rotate) begin
                r_row_out <= {r_row_out[c_NUM_LINES-2:0], r_row_out[c_NUM_LINES-1]};
                r_row_idx <= r_row_idx + 2'd1;
            end
            if (w_latch)  r_col_idx  <= w_col_low;
            if (w_accept) r_key_code <= {r_row_idx, r_col_idx};
            r_key_valid <= w_accept;
            if (w_accept)       r_key_held <= 1'b1;
            else if (w_release) r_key_held <= 1'b0;
        end
    end

    assign rowOut   = r_row_out;
    assign keyCode  = r_key_code;
    assign keyValid = r_key_valid;
    assign keyHeld  = r_key_held;

endmodule
`default_nettype wire
